xbar_credit_ctrl: RTL and testbench
===================================

# xbar_credit_ctrl

Credit-based crossbar launch controller for the 5-port router. Sits between the switch allocator and the crossbar/input buffers. Each cycle it takes the allocator's per-input target grants and checks each target output's downstream credit count. It issues registered pop strobes to the input buffers (the same `pop_ctrl` the allocator consumes), crossbar select codes, and per-output flit-valid pulses, and it tracks downstream buffer occupancy with per-output credit counters.

## Interface
Parameters:
- CREDITS, 4: downstream buffer depth per output; credit counter reset value.
- CW, 3: credit counter width; CREDITS ≤ 2^CW−1 required.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- grant_pack  in  15  3-bit target per input; input i in bits [3i+2:3i]; 0 = no grant, 1–5 = output port; 6–7 treated as 0.
- in_valid  in  5  input buffer i non-empty (head flit present).
- credit_ret  in  5  one-cycle pulse: downstream of output o freed one slot.
- pop_ctrl  out  5  registered pop strobe to input buffer i; also fed back to allocator.
- sel_pack  out  15  crossbar select per output; output o in bits [3o+2:3o]; 0 = idle, 1–5 = source input.
- out_valid  out  5  registered flit-valid on output o.
- credit_avail  out  5  registered; bit o = credit counter o nonzero.
- err_ovf  out  1  sticky: credit returned to a full counter.
- err_conflict  out  1  sticky: two launch-eligible inputs targeted the same output in one cycle.

## Operation
- Input i is eligible in cycle t when all three hold: grant g = grant_pack[i] ∈ 1..5, in_valid[i] = 1, and cnt[g−1] > 0. The count used is the registered value at the start of cycle t.
- Per output o, the winner is the lowest-index eligible input targeting o+1. If more than one eligible input targets o, err_conflict is set and the others are not launched.
- On launch of input i to output o at the edge ending cycle t:
  - pop_ctrl[i] = 1
  - sel[o] = i+1
  - out_valid[o] = 1
  - all three are visible for exactly cycle t+1.
- Non-launching inputs/outputs: pop_ctrl = 0, sel = 0, out_valid = 0 in t+1. No output holds its value across cycles.
- Credit counter o, per cycle:
  - launch only: −1.
  - credit_ret[o] only: +1.
  - both: unchanged.
  - neither: unchanged.
- credit_ret[o] with cnt[o] = CREDITS and no same-cycle launch on o: counter stays at CREDITS and err_ovf is set.
- Launch requires cnt > 0, so a counter never goes below 0.
- err_ovf and err_conflict hold until rst.
- credit_avail[o] = (next cnt[o] ≠ 0), registered alongside the counter.

## Timing
- Reset (rst high at an edge) forces:
  - all cnt = CREDITS
  - pop_ctrl = 0, sel_pack = 0, out_valid = 0
  - credit_avail = 5'b11111
  - err_ovf = 0, err_conflict = 0
- Reset mid-operation discards any pending launch, and any credit_ret arriving in the same cycle is ignored.
- Latency is one cycle: grant/in_valid in cycle t produce pop/sel/out_valid in t+1.
- A credit_ret pulse in cycle t is usable for eligibility in cycle t+1, not in t.
- Back-to-back launches from one input to one output are allowed every cycle while credits and in_valid last.
- With CREDITS = 4 and no returns, at most 4 consecutive launches per output; the 5th is blocked.
- Single-cycle eligibility path only: no multicycle or combinational output paths. Every output is a flop.

## Test plan
- Reset check: hold rst 2 cycles, then release with all inputs 0. Required: pop_ctrl = 0, sel_pack = 0, out_valid = 0, credit_avail = 5'h1F, both errors 0.
- Basic launch: grant_pack = input0→3, in_valid = 5'b00001 for one cycle. Next cycle required: pop_ctrl = 5'b00001, sel[2] = 1, out_valid = 5'b00100; cnt[2] = 3.
- Credit exhaustion: input1→2 held valid for 6 cycles, no credit_ret. Required: exactly 4 pops/out_valid pulses on cycles 2–5; credit_avail[1] = 0 after the 4th; no launch on cycles 6–7. Then one credit_ret[1] pulse: exactly one further launch, one cycle after the pulse.
- Simultaneous launch and return: cnt[0] = 1, launch on output 0 in the same cycle as credit_ret[0]. Required: cnt stays 1, credit_avail[0] stays 1, out_valid[0] = 1.
- Conflict: inputs 2 and 4 both →5 and valid. Required: only pop_ctrl[2], sel[4] = 3, err_conflict = 1 and sticky until rst.
- Overflow: credit_ret[3] pulse at cnt = 4 with no launch. Required: cnt stays 4, err_ovf = 1. A following rst clears it to 0.

Source files
------------

// File: rtl/xbar_credit_ctrl.sv
// xbar_credit_ctrl
// Launch controller for the 5-port router crossbar. For each input it takes
// the allocator's target grant and checks that output's downstream credits.
// For every launching input it registers a pop strobe, a crossbar select and
// a flit-valid pulse. It also keeps one credit counter per output.
module xbar_credit_ctrl #(
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] grant_pack,
  input  logic [4:0]  in_valid,
  input  logic [4:0]  credit_ret,
  output logic [4:0]  pop_ctrl,
  output logic [14:0] sel_pack,
  output logic [4:0]  out_valid,
  output logic [4:0]  credit_avail,
  output logic        err_ovf,
  output logic        err_conflict
);

  localparam int NP = 5;
  localparam logic [CW-1:0] FULL = CW'(CREDITS);

  logic [CW-1:0]   cnt_q [NP];
  logic [CW-1:0]   cnt_d [NP];
  logic [NP-1:0]   pop_q, pop_d;
  logic [3*NP-1:0] sel_q, sel_d;
  logic [NP-1:0]   ov_q, ov_d;
  logic [NP-1:0]   avail_q, avail_d;
  logic            ovf_q, ovf_d;
  logic            conf_q, conf_d;

  logic [2:0]      tgt [NP];
  logic [NP-1:0]   cntNz;
  logic [NP-1:0]   elig;
  logic [NP-1:0]   launch;
  logic [NP-1:0]   conflictHit;
  logic [NP-1:0]   ovfHit;

  // Flag which outputs have credit left at the start of this cycle
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      cntNz[o] = (cnt_q[o] != '0);
    end
  end

  // Decode each input's target. A target of 0, 6 or 7 never matches an output.
  // The input is eligible only if it has a head flit and its target has credit.
  always_comb begin
    for (int i = 0; i < NP; i++) begin
      tgt[i]  = grant_pack[3*i +: 3];
      elig[i] = 1'b0;
      for (int o = 0; o < NP; o++) begin
        if (tgt[i] == 3'(o + 1) && in_valid[i] && cntNz[o]) begin
          elig[i] = 1'b1;
        end
      end
    end
  end

  // Per output, the lowest-index eligible input wins.
  // Any further eligible input on the same output is a conflict and does not launch.
  always_comb begin
    pop_d       = '0;
    sel_d       = '0;
    launch      = '0;
    conflictHit = '0;
    for (int o = 0; o < NP; o++) begin
      for (int i = 0; i < NP; i++) begin
        if (elig[i] && tgt[i] == 3'(o + 1)) begin
          if (!launch[o]) begin
            launch[o]        = 1'b1;
            pop_d[i]         = 1'b1;
            sel_d[3*o +: 3]  = 3'(i + 1);
          end else begin
            conflictHit[o] = 1'b1;
          end
        end
      end
    end
    ov_d = launch;
  end

  // Update the credit counters. A launch and a return in the same cycle
  // cancel out. A return into a full counter is dropped and flagged.
  always_comb begin
    for (int o = 0; o < NP; o++) begin
      cnt_d[o]  = cnt_q[o];
      ovfHit[o] = 1'b0;
      if (launch[o] && !credit_ret[o]) begin
        cnt_d[o] = cnt_q[o] - CW'(1);
      end else if (!launch[o] && credit_ret[o]) begin
        if (cnt_q[o] == FULL) begin
          ovfHit[o] = 1'b1;
        end else begin
          cnt_d[o] = cnt_q[o] + CW'(1);
        end
      end
      avail_d[o] = (cnt_d[o] != '0);
    end
    ovf_d  = ovf_q  | (|ovfHit);
    conf_d = conf_q | (|conflictHit);
  end

  // Register all state and outputs. Reset discards the launch decided this cycle
  // and ignores any credit returns that arrive with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < NP; o++) begin
        cnt_q[o] <= FULL;
      end
      pop_q   <= '0;
      sel_q   <= '0;
      ov_q    <= '0;
      avail_q <= '1;
      ovf_q   <= 1'b0;
      conf_q  <= 1'b0;
    end else begin
      for (int o = 0; o < NP; o++) begin
        cnt_q[o] <= cnt_d[o];
      end
      pop_q   <= pop_d;
      sel_q   <= sel_d;
      ov_q    <= ov_d;
      avail_q <= avail_d;
      ovf_q   <= ovf_d;
      conf_q  <= conf_d;
    end
  end

  assign pop_ctrl     = pop_q;
  assign sel_pack     = sel_q;
  assign out_valid    = ov_q;
  assign credit_avail = avail_q;
  assign err_ovf      = ovf_q;
  assign err_conflict = conf_q;

endmodule

// File: tb/tb_xbar_credit_ctrl.sv
// Testbench for xbar_credit_ctrl.
// Directed vectors queue their hand-computed expected outputs, tagged with the
// cycle in which they must appear. A monitor pops each entry and compares it.
module tb_xbar_credit_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] grant_pack = '0;
  logic [4:0]  in_valid = '0;
  logic [4:0]  credit_ret = '0;
  logic [4:0]  pop_ctrl;
  logic [14:0] sel_pack;
  logic [4:0]  out_valid;
  logic [4:0]  credit_avail;
  logic        err_ovf;
  logic        err_conflict;

  typedef struct {
    int          cyc;
    logic [4:0]  pop;
    logic [14:0] sel;
    logic [4:0]  ov;
    logic [4:0]  avail;
    logic        ovf;
    logic        conf;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  xbar_credit_ctrl #(.CREDITS(4), .CW(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .grant_pack   (grant_pack),
    .in_valid     (in_valid),
    .credit_ret   (credit_ret),
    .pop_ctrl     (pop_ctrl),
    .sel_pack     (sel_pack),
    .out_valid    (out_valid),
    .credit_avail (credit_avail),
    .err_ovf      (err_ovf),
    .err_conflict (err_conflict)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Count rising edges so queued expectations can name the cycle they belong to
  always @(posedge clk) cyc <= cyc + 1;

  // Place a 3-bit value in slot idx of a packed 5x3 field
  function automatic logic [14:0] fld(input int idx, input int val);
    logic [14:0] v;
    v = '0;
    v[3*idx +: 3] = 3'(val);
    return v;
  endfunction

  task automatic checkField(input string nm, input logic [14:0] act, input logic [14:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    checkField({e.name, "/pop"},   15'(pop_ctrl),     15'(e.pop));
    checkField({e.name, "/sel"},   sel_pack,          e.sel);
    checkField({e.name, "/ov"},    15'(out_valid),    15'(e.ov));
    checkField({e.name, "/avail"}, 15'(credit_avail), 15'(e.avail));
    checkField({e.name, "/ovf"},   15'(err_ovf),      15'(e.ovf));
    checkField({e.name, "/conf"},  15'(err_conflict), 15'(e.conf));
  endtask

  // Monitor: on the falling edge, compare every expectation due by now
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput(e);
    end
  end

  // Drive one cycle of inputs just after the edge.
  // Queue the outputs expected after the next rising edge.
  task automatic applyStimulus(input logic r, input logic [14:0] g, input logic [4:0] v,
                               input logic [4:0] ret, input logic [4:0] ePop,
                               input logic [14:0] eSel, input logic [4:0] eOv,
                               input logic [4:0] eAv, input logic eOvf, input logic eConf,
                               input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst        = r;
    grant_pack = g;
    in_valid   = v;
    credit_ret = ret;
    e.cyc   = cyc + 1;
    e.pop   = ePop;
    e.sel   = eSel;
    e.ov    = eOv;
    e.avail = eAv;
    e.ovf   = eOvf;
    e.conf  = eConf;
    e.name  = nm;
    expQ.push_back(e);
  endtask

  initial begin
    // Reset held two cycles, then released with idle inputs
    applyStimulus(1, '0, '0, '0, '0, '0, '0, 5'h1F, 0, 0, "reset1");
    applyStimulus(1, '0, '0, '0, '0, '0, '0, 5'h1F, 0, 0, "reset2");
    applyStimulus(0, '0, '0, '0, '0, '0, '0, 5'h1F, 0, 0, "release");

    // Basic launch: input0 to output port 3
    applyStimulus(0, fld(0, 3), 5'h01, '0, 5'h01, fld(2, 1), 5'h04, 5'h1F, 0, 0, "basic");
    applyStimulus(0, '0, '0, '0, '0, '0, '0, 5'h1F, 0, 0, "idle1");

    // Credit exhaustion on output index 1: four launches, then two blocked cycles
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, fld(1, 2), 5'h02, '0, 5'h02, fld(1, 2), 5'h02,
                    (k == 3) ? 5'h1D : 5'h1F, 0, 0, $sformatf("exhaust%0d", k));
    end
    applyStimulus(0, fld(1, 2), 5'h02, '0, '0, '0, '0, 5'h1D, 0, 0, "blocked5");
    applyStimulus(0, fld(1, 2), 5'h02, '0, '0, '0, '0, 5'h1D, 0, 0, "blocked6");
    applyStimulus(0, fld(1, 2), 5'h02, 5'h02, '0, '0, '0, 5'h1F, 0, 0, "retCycle");
    applyStimulus(0, fld(1, 2), 5'h02, '0, 5'h02, fld(1, 2), 5'h02, 5'h1D, 0, 0, "relaunch");
    applyStimulus(0, fld(1, 2), 5'h02, '0, '0, '0, '0, 5'h1D, 0, 0, "afterRelaunch");

    // Drain output 0 to one credit, then launch and return in the same cycle
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, fld(0, 1), 5'h01, '0, 5'h01, fld(0, 1), 5'h01, 5'h1D, 0, 0,
                    $sformatf("drain%0d", k));
    end
    applyStimulus(0, fld(0, 1), 5'h01, 5'h01, 5'h01, fld(0, 1), 5'h01, 5'h1D, 0, 0, "launchAndRet");
    applyStimulus(0, fld(0, 1), 5'h01, '0, 5'h01, fld(0, 1), 5'h01, 5'h1C, 0, 0, "lastCredit0");
    applyStimulus(0, fld(0, 1), 5'h01, '0, '0, '0, '0, 5'h1C, 0, 0, "empty0");

    // Conflict: inputs 2 and 4 both target port 5, and the lower index wins
    applyStimulus(0, fld(2, 5) | fld(4, 5), 5'h14, '0, 5'h04, fld(4, 3), 5'h10, 5'h1C, 0, 1, "conflict");
    applyStimulus(0, '0, '0, '0, '0, '0, '0, 5'h1C, 0, 1, "confSticky");

    // Two parallel launches, with input 2 carrying the ignored grant code 7
    applyStimulus(0, fld(4, 3) | fld(3, 5) | fld(2, 7), 5'h1C, '0, 5'h18,
                  fld(2, 5) | fld(4, 4), 5'h14, 5'h1C, 0, 1, "parallel");
    applyStimulus(0, fld(3, 4), '0, '0, '0, '0, '0, 5'h1C, 0, 1, "noValid");
    applyStimulus(0, fld(2, 6), 5'h04, '0, '0, '0, '0, 5'h1C, 0, 1, "grant6");

    // Overflow: credit return into the full counter of output index 3
    applyStimulus(0, '0, '0, 5'h08, '0, '0, '0, 5'h1C, 1, 1, "overflow");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, fld(3, 4), 5'h08, '0, 5'h08, fld(3, 4), 5'h08,
                    (k == 3) ? 5'h14 : 5'h1C, 1, 1, $sformatf("ovfDrain%0d", k));
    end
    applyStimulus(0, fld(3, 4), 5'h08, '0, '0, '0, '0, 5'h14, 1, 1, "ovfBlocked");

    // Reset mid-operation with a pending launch and returns, then recovery
    applyStimulus(1, fld(0, 1), 5'h01, 5'h1F, '0, '0, '0, 5'h1F, 0, 0, "resetMid");
    applyStimulus(0, '0, '0, '0, '0, '0, '0, 5'h1F, 0, 0, "postReset");
    applyStimulus(0, fld(0, 1), 5'h01, '0, 5'h01, fld(0, 1), 5'h01, 5'h1F, 0, 0, "postResetLaunch");
    applyStimulus(0, '0, '0, '0, '0, '0, '0, 5'h1F, 0, 0, "finalIdle");

    // Give the monitor a bounded window to consume the remaining expectations
    for (int k = 0; k < 20 && expQ.size() > 0; k++) @(negedge clk);
    @(negedge clk);
    if (expQ.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: got %0d pending required 0 pending", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
